// File: rtl/adc_tape_slicer.sv
`default_nettype none
// ============================================================================
// Module      : adc_tape_slicer
// Description : Cassette bit slicer. Running power-of-two window average over
//               a circular sample RAM, hysteresis compare and deglitch filter.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_tape_slicer #(
    parameter int SAMPLE_W = 12,
    parameter int AVG_LOG2 = 9,
    parameter int DEGLITCH = 1,
    parameter int INVERT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_sync,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [SAMPLE_W-1:0] hyst,
    output logic                bit_out,
    output logic                bit_valid,
    output logic                bit_edge,    // the edge pulse; "edge" is a reserved word
    output logic [SAMPLE_W-1:0] avg_out,
    output logic                ready,
    output logic                overrun
);
    localparam int   DEPTH     = 1 << AVG_LOG2;
    localparam int   TOT_W     = SAMPLE_W + AVG_LOG2;
    localparam int   CMP_W     = SAMPLE_W + 2;
    localparam int   CNT_W     = 4;
    localparam logic RAW_BELOW = (INVERT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_ACC    = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_sync_d;
    logic                  w_new;
    logic [SAMPLE_W-1:0]   r_s_new;
    logic [SAMPLE_W-1:0]   r_rd_data;
    logic [SAMPLE_W-1:0]   w_oldest;
    logic [SAMPLE_W-1:0]   r_ram [DEPTH];
    logic [AVG_LOG2-1:0]   r_wptr;
    logic                  r_filled;
    logic [TOT_W-1:0]      r_total;
    logic                  r_raw;
    logic                  w_raw_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic signed [CMP_W-1:0] w_sample_s;
    logic signed [CMP_W-1:0] w_lo;
    logic signed [CMP_W-1:0] w_hi;

    assign w_new     = (sample_sync != r_sync_d);
    assign w_oldest  = r_filled ? r_rd_data : '0;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Two guard bits keep avg-hyst and avg+hyst from wrapping at the rails.
    assign w_sample_s = $signed({2'b00, r_s_new});
    assign w_lo       = $signed({2'b00, avg_out}) - $signed({2'b00, hyst});
    assign w_hi       = $signed({2'b00, avg_out}) + $signed({2'b00, hyst});

    always_comb begin
        w_raw_next = r_raw;
        if (w_sample_s < w_lo) begin
            w_raw_next = RAW_BELOW;
        end else if (w_sample_s > w_hi) begin
            w_raw_next = ~RAW_BELOW;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_new) w_state_next = ST_READ;
            ST_READ:   w_state_next = ST_ACC;
            ST_ACC:    w_state_next = ST_DECIDE;
            ST_DECIDE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sample RAM carries no reset; r_filled masks stale contents after reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_READ) begin
            r_rd_data <= r_ram[r_wptr];
        end
        if (r_state == ST_ACC) begin
            r_ram[r_wptr] <= r_s_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_d  <= 1'b0;
            r_s_new   <= '0;
            r_wptr    <= '0;
            r_filled  <= 1'b0;
            r_total   <= '0;
            r_raw     <= 1'b0;
            r_cnt     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_edge  <= 1'b0;
            avg_out   <= '0;
            ready     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_sync_d  <= sample_sync;
            bit_valid <= 1'b0;
            bit_edge  <= 1'b0;

            if (w_new) begin
                if (r_state == ST_IDLE) begin
                    r_s_new <= sample_in;
                end else begin
                    overrun <= 1'b1;
                end
            end

            if (r_state == ST_ACC) begin
                r_total <= r_total - {{AVG_LOG2{1'b0}}, w_oldest}
                                   + {{AVG_LOG2{1'b0}}, r_s_new};
                r_wptr  <= r_wptr + AVG_LOG2'(1);
                if (&r_wptr) begin
                    r_filled <= 1'b1;
                end
            end

            if (r_state == ST_DECIDE) begin
                avg_out   <= r_total[TOT_W-1:AVG_LOG2];
                ready     <= r_filled;
                bit_valid <= 1'b1;
                // Compare uses avg_out before this load, i.e. the previous average.
                if (ready) begin
                    r_raw <= w_raw_next;
                    if (w_raw_next == bit_out) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == CNT_W'(DEGLITCH)) begin
                        bit_out  <= w_raw_next;
                        bit_edge <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_tape_slicer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_tape_slicer
// Description : Self-checking bench; three slicer variants against a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_tape_slicer;
    localparam int SW   = 12;
    localparam int AL   = 4;
    localparam int WIN  = 1 << AL;
    localparam int NDUT = 3;
    localparam int DG  [NDUT] = '{1, 3, 2};
    localparam int INV [NDUT] = '{1, 1, 0};

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic          sample_sync = 1'b0;
    logic [SW-1:0] sample_in   = '0;
    logic [SW-1:0] hyst        = '0;
    logic [NDUT-1:0] bo, bv, be, rdy, ovr;
    logic [SW-1:0]   avg [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int win[$];
    int m_count;
    int m_avg;
    bit m_raw  [NDUT];
    bit m_bit  [NDUT];
    bit m_edge [NDUT];
    int m_cnt  [NDUT];

    // Snapshot taken on the bit_valid cycle
    int              o_lat;
    int              o_extra;
    logic [NDUT-1:0] o_bo, o_be, o_bv, o_rdy, o_ovr;
    logic [SW-1:0]   o_avg [NDUT];

    always #5 clk = ~clk;

    adc_tape_slicer #(.SAMPLE_W(SW), .AVG_LOG2(AL), .DEGLITCH(1), .INVERT(1)) u_dut_a (
        .clk(clk), .reset(reset), .sample_sync(sample_sync), .sample_in(sample_in),
        .hyst(hyst), .bit_out(bo[0]), .bit_valid(bv[0]), .bit_edge(be[0]),
        .avg_out(avg[0]), .ready(rdy[0]), .overrun(ovr[0]));
    adc_tape_slicer #(.SAMPLE_W(SW), .AVG_LOG2(AL), .DEGLITCH(3), .INVERT(1)) u_dut_b (
        .clk(clk), .reset(reset), .sample_sync(sample_sync), .sample_in(sample_in),
        .hyst(hyst), .bit_out(bo[1]), .bit_valid(bv[1]), .bit_edge(be[1]),
        .avg_out(avg[1]), .ready(rdy[1]), .overrun(ovr[1]));
    adc_tape_slicer #(.SAMPLE_W(SW), .AVG_LOG2(AL), .DEGLITCH(2), .INVERT(0)) u_dut_c (
        .clk(clk), .reset(reset), .sample_sync(sample_sync), .sample_in(sample_in),
        .hyst(hyst), .bit_out(bo[2]), .bit_valid(bv[2]), .bit_edge(be[2]),
        .avg_out(avg[2]), .ready(rdy[2]), .overrun(ovr[2]));

    function automatic void model_reset();
        win.delete();
        m_count = 0;
        m_avg   = 0;
        for (int d = 0; d < NDUT; d++) begin
            m_raw[d] = 1'b0; m_bit[d] = 1'b0; m_edge[d] = 1'b0; m_cnt[d] = 0;
        end
    endfunction

    // Average = mean of the last WIN samples (missing ones count as zero).
    function automatic void model_step(input int s);
        int  h;
        int  sum;
        bit  r;
        bit  was_ready;
        h         = int'(hyst);
        was_ready = (m_count >= WIN);
        for (int d = 0; d < NDUT; d++) begin
            m_edge[d] = 1'b0;
            if (was_ready) begin
                r = m_raw[d];
                if (s < m_avg - h)      r = (INV[d] != 0);
                else if (s > m_avg + h) r = (INV[d] == 0);
                m_raw[d] = r;
                if (r == m_bit[d]) begin
                    m_cnt[d] = 0;
                end else begin
                    m_cnt[d]++;
                    if (m_cnt[d] >= DG[d]) begin
                        m_bit[d]  = r;
                        m_edge[d] = 1'b1;
                        m_cnt[d]  = 0;
                    end
                end
            end
        end
        win.push_back(s);
        if (win.size() > WIN) void'(win.pop_front());
        sum = 0;
        foreach (win[i]) sum += win[i];
        m_avg = sum / WIN;
        m_count++;
    endfunction

    task automatic apply_reset(input int h);
        @(negedge clk);
        reset       = 1'b1;
        sample_sync = 1'b0;
        hyst        = h[SW-1:0];
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Drive one sample, capture outputs on the bit_valid cycle, then pad to gap.
    task automatic send(input int s, input int gap);
        bit seen;
        sample_in   = s[SW-1:0];
        sample_sync = ~sample_sync;
        model_step(s);
        seen    = 1'b0;
        o_lat   = 0;
        o_extra = 0;
        o_bo = '0; o_be = '0; o_bv = '0; o_rdy = '0; o_ovr = '0;
        for (int d = 0; d < NDUT; d++) o_avg[d] = '0;
        while (!seen && o_lat < 12) begin
            @(negedge clk);
            o_lat++;
            if (bv[0]) begin
                seen = 1'b1;
                o_bo = bo; o_be = be; o_bv = bv; o_rdy = rdy; o_ovr = ovr;
                for (int d = 0; d < NDUT; d++) o_avg[d] = avg[d];
            end
        end
        for (int c = o_lat; c < gap; c++) begin
            @(negedge clk);
            if (bv != '0 || be != '0) o_extra++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; sample_sync = 1'b0; hyst = 12'd100;
        model_reset();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_tests++;
            if ({bo[d], bv[d], be[d], rdy[d], ovr[d], avg[d]} !== 17'd0) begin
                n_fail++;
                $display("FAIL reset_in dut%0d: got %b/%0d required all zero",
                         d, {bo[d], bv[d], be[d], rdy[d], ovr[d]}, avg[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({bo, bv, be, rdy, ovr} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_after: got %b required 0", {bo, bv, be, rdy, ovr});
        end
    endtask

    task automatic test_fill();
        apply_reset(100);
        for (int i = 1; i <= WIN; i++) begin
            send(2000, 10);
            n_tests++;
            if (o_lat !== 4) begin
                n_fail++; $display("FAIL fill_latency: got %0d required 4", o_lat);
            end
            n_tests++;
            if (o_rdy !== ((i == WIN) ? 3'b111 : 3'b000)) begin
                n_fail++; $display("FAIL fill_ready sample %0d: got %b", i, o_rdy);
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            n_tests++;
            if (o_avg[d] !== 12'd2000 || o_bo[d] !== 1'b0 || o_ovr[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_final dut%0d: avg %0d bit %b ovr %b required 2000 0 0",
                         d, o_avg[d], o_bo[d], o_ovr[d]);
            end
        end
    endtask

    task automatic test_step();
        int  vals [3] = '{1850, 1950, 2150};
        bit  ebit [3] = '{1'b1, 1'b1, 1'b0};
        bit  eedg [3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            send(vals[k], 10);
            n_tests++;
            if (o_bo[0] !== ebit[k] || o_be[0] !== eedg[k]) begin
                n_fail++;
                $display("FAIL step_%0d: bit %b edge %b required %b %b",
                         vals[k], o_bo[0], o_be[0], ebit[k], eedg[k]);
            end
            for (int d = 1; d < NDUT; d++) begin
                n_tests++;
                if (o_bo[d] !== m_bit[d] || o_be[d] !== m_edge[d]) begin
                    n_fail++;
                    $display("FAIL step_model dut%0d: bit %b edge %b required %b %b",
                             d, o_bo[d], o_be[d], m_bit[d], m_edge[d]);
                end
            end
        end
    endtask

    task automatic test_deglitch();
        apply_reset(0);
        for (int i = 0; i < WIN; i++) send(2000, 8);
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 0) ? 1800 : 2000, 8);
            n_tests++;
            if (o_bo[1] !== 1'b0 || o_be[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL deglitch_alt %0d: bit %b edge %b required 0 0", i, o_bo[1], o_be[1]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            send(1800, 8);
            n_tests++;
            if (o_bo[1] !== (k == 2) || o_be[1] !== (k == 2)) begin
                n_fail++;
                $display("FAIL deglitch_run %0d: bit %b edge %b required %b",
                         k, o_bo[1], o_be[1], (k == 2));
            end
        end
    endtask

    task automatic test_boundary();
        int fills [2] = '{50, 4050};
        int probe [2] = '{0, 4095};
        for (int t = 0; t < 2; t++) begin
            apply_reset(100);
            for (int i = 0; i < WIN; i++) send(fills[t], 6);
            send(probe[t], 6);
            for (int d = 0; d < NDUT; d++) begin
                n_tests++;
                if (o_bo[d] !== 1'b0 || o_be[d] !== 1'b0 || o_avg[d] !== SW'(m_avg)) begin
                    n_fail++;
                    $display("FAIL boundary_%0d dut%0d: bit %b edge %b avg %0d required 0 0 %0d",
                             probe[t], d, o_bo[d], o_be[d], o_avg[d], m_avg);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int pulses;
        apply_reset(100);
        sample_in   = 12'd1000;
        sample_sync = ~sample_sync;
        model_step(1000);
        @(negedge clk);
        @(negedge clk);
        sample_in   = 12'd3000;
        sample_sync = ~sample_sync;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bv[0]) pulses++;
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL overrun_pulses: got %0d required 1", pulses);
        end
        n_tests++;
        if (ovr !== 3'b111 || avg[0] !== SW'(m_avg)) begin
            n_fail++;
            $display("FAIL overrun_flag: ovr %b avg %0d required 111 %0d", ovr, avg[0], m_avg);
        end
        for (int i = 0; i < 3; i++) begin
            send(1000, 8);
            n_tests++;
            if (o_ovr !== 3'b111) begin
                n_fail++; $display("FAIL overrun_sticky: got %b required 111", o_ovr);
            end
        end
        apply_reset(100);
        n_tests++;
        if (ovr !== 3'b000) begin
            n_fail++; $display("FAIL overrun_clear: got %b required 000", ovr);
        end
    endtask

    task automatic test_reset_midfill();
        apply_reset(100);
        for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 4095)), 5);
        apply_reset(100);
        for (int i = 1; i <= WIN; i++) begin
            send(1000, 5);
            n_tests++;
            if (o_rdy !== ((i == WIN) ? 3'b111 : 3'b000)) begin
                n_fail++; $display("FAIL midfill_ready sample %0d: got %b", i, o_rdy);
            end
        end
        n_tests++;
        if (o_avg[0] !== 12'd1000) begin
            n_fail++; $display("FAIL midfill_avg: got %0d required 1000", o_avg[0]);
        end
    endtask

    task automatic test_random();
        int s;
        apply_reset(int'($urandom_range(0, 200)));
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 7))
                0:       s = 0;
                1:       s = 4095;
                default: s = 2048 + int'($urandom_range(0, 1200)) - 600;
            endcase
            send(s, int'($urandom_range(4, 7)));
            n_tests++;
            if (o_lat !== 4 || o_extra !== 0 || o_bv !== 3'b111) begin
                n_fail++;
                $display("FAIL rand_timing %0d: lat %0d extra %0d valid %b required 4 0 111",
                         i, o_lat, o_extra, o_bv);
            end
            for (int d = 0; d < NDUT; d++) begin
                n_tests++;
                if (o_bo[d] !== m_bit[d] || o_be[d] !== m_edge[d] ||
                    o_avg[d] !== SW'(m_avg) || o_rdy[d] !== (m_count >= WIN)) begin
                    n_fail++;
                    $display("FAIL rand_model %0d dut%0d: bit %b edge %b avg %0d rdy %b required %b %b %0d %b",
                             i, d, o_bo[d], o_be[d], o_avg[d], o_rdy[d],
                             m_bit[d], m_edge[d], m_avg, (m_count >= WIN));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_step();
        test_deglitch();
        test_boundary();
        test_overrun();
        test_reset_midfill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adc_tape_slicer.md
# adc_tape_slicer

Parametrised cassette-input bit slicer between the `ltc2308` ADC sampler and the machine's cassette data input (`casdout`). On each ADC sample it keeps a power-of-two running average over a circular sample RAM, compares the sample against that average with a programmable hysteresis band, and deglitches the result. It emits a cassette bit, a per-sample valid strobe, edge pulses and status. It replaces the fixed 512-tap shift-register average and makes depth, width, hysteresis, polarity and filtering configurable.

## Interface
- `SAMPLE_W`, 12: ADC sample width in bits.
- `AVG_LOG2`, 9: log2 of the averaging window depth (window = 2^AVG_LOG2 samples); valid range 2..12.
- `DEGLITCH`, 1: number of consecutive agreeing raw decisions required before `bit_out` changes; valid range 1..15.
- `INVERT`, 1: 1 = below-average drives `bit_out`=1 (CoCo polarity); 0 = above-average drives `bit_out`=1.

- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `sample_sync` in 1: toggle strobe from the ADC, synchronous to `clk`; any change marks a new sample.
- `sample_in` in SAMPLE_W: unsigned ADC sample; valid when `sample_sync` changes.
- `hyst` in SAMPLE_W: unsigned hysteresis half-band; static during operation.
- `bit_out` out 1: sliced cassette bit.
- `bit_valid` out 1: one-cycle pulse for each processed sample.
- `edge` out 1: one-cycle pulse, coincident with `bit_valid`, whenever `bit_out` changes.
- `avg_out` out SAMPLE_W: current window average.
- `ready` out 1: high once the window has filled.
- `overrun` out 1: sticky flag, set when a sample is dropped.

## Operation
- Toggle detect: `sync_d` holds the previous `sample_sync`. New sample when `sample_sync != sync_d`; `sample_in` is latched into `s_new` on that edge.
- Pipeline FSM with states IDLE, READ, ACC, DECIDE, then back to IDLE:
  - IDLE: a detected sample latches it and moves to READ.
  - READ: reads `ram[wptr]`, the oldest entry (read-before-write).
  - ACC: `oldest` = RAM data if `filled`, else 0. Computes `total <= total - oldest + s_new`. Writes `ram[wptr] <= s_new`, then `wptr <= wptr+1` (mod 2^AVG_LOG2). When `wptr` wraps to 0 for the first time, `filled` sets.
  - DECIDE: compares `s_new` against `avg_out` as it stood before this sample's update, then loads `avg_out <= total[SAMPLE_W+AVG_LOG2-1:AVG_LOG2]`.
- `total` is SAMPLE_W+AVG_LOG2 bits wide and cannot overflow. The comparison is done in SAMPLE_W+2-bit signed arithmetic, so `avg-hyst` < 0 and `avg+hyst` > max never wrap.
- Raw decision (INVERT=1):
  - `s_new < avg-hyst` gives raw=1.
  - `s_new > avg+hyst` gives raw=0.
  - Otherwise raw holds its previous value.
  - INVERT=0 swaps the two assignments.
- Deglitch:
  - If raw equals `bit_out`, the counter clears.
  - Otherwise the counter increments; on reaching DEGLITCH, `bit_out` takes raw, `edge` pulses and the counter clears.
- Decisions are made only while `ready`=1. During fill, `bit_out` holds 0 but `bit_valid` still pulses.
- A new sample detected in any state other than IDLE is dropped: `overrun` sets and the in-flight sample completes normally.
- Reset mid-operation: all registers return to reset values and fill restarts. RAM contents are not cleared; `filled`=0 masks them.

## Timing
- Reset values:
  - outputs: `bit_out`=0, `bit_valid`=0, `edge`=0, `avg_out`=0, `ready`=0, `overrun`=0;
  - internal: `total`=0, `wptr`=0, deglitch counter 0, raw 0, FSM in IDLE.
- Latency: toggle seen at edge E0. `bit_valid` (and `edge`, `avg_out` update) are asserted in the cycle after E3.
- Minimum sample spacing is 4 clocks; closer samples raise `overrun`.
- `ready` rises at the DECIDE of sample number 2^AVG_LOG2 and stays high until reset.
- `bit_valid` and `edge` are single-cycle pulses, never back-to-back.

## Test plan
- Fill: AVG_LOG2=4, feed 16 samples of 2000 spaced 10 clocks apart. Required: `ready` rises with the 16th `bit_valid`, `avg_out`=2000, `bit_out`=0, `overrun`=0.
- Step with hysteresis: after fill at 2000, hyst=100, DEGLITCH=1, INVERT=1.
  - Sample 1850: `bit_out`=1 and `edge` pulses.
  - Sample 1950: no change (inside band).
  - Sample 2150: `bit_out`=0 and `edge` pulses.
- Deglitch: DEGLITCH=3, alternate 1800/2000 after fill. Required: `bit_out` never changes. Then three consecutive 1800 samples: `bit_out`=1 on the third.
- Boundary arithmetic: fill at 50, hyst=100, feed 0. Required: no transition (no underflow). Fill at 4050, feed 4095: no transition.
- Overrun: two toggles 2 clocks apart. Required: one `bit_valid`, `overrun`=1 and sticky until reset.
- Reset mid-fill: assert `reset` after 10 samples, release, feed 16 samples of 1000. Required: `ready` rises only on the 16th post-reset sample, `avg_out`=1000.
